nibble_parity_tx: RTL

//   Serial transmitter downstream of the 4-bit parity generator stage. Accepts a
//   4-bit nibble over a valid/ready handshake and computes its parity internally.

---
 rtl/nibble_parity_tx.sv | 108 ++++++++++
 1 files changed

// File: rtl/nibble_parity_tx.sv
// Serial frame transmitter for one parity-protected nibble.
// Frame: start, 4 data bits LSB first, parity, stop; each bit CLKS_PER_BIT cycles.
module nibble_parity_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       par_out
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cyc_cnt;
  logic [1:0]    bit_cnt;
  logic [3:0]    shreg;
  logic          accept;
  logic          bit_end;

  assign accept  = din_valid && (state == IDLE);
  assign bit_end = (state != IDLE) && (cyc_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_out <= 1'b0;
    end else begin
      if (state == IDLE || bit_end) begin
        cyc_cnt <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end

      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (bit_end) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      // Capture on accept; later din changes never reach the frame
      if (accept) begin
        shreg   <= din;
        par_out <= (^din) ^ PARITY_ODD;
      end else if (state == DATA && bit_end) begin
        shreg <= {1'b0, shreg[3:1]};
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = START;
      START:   if (bit_end) state_nx = DATA;
      DATA:    if (bit_end && bit_cnt == 2'd3) state_nx = PARITY;
      PARITY:  if (bit_end) state_nx = STOP;
      STOP:    if (bit_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx        = 1'b1;
    busy      = 1'b1;
    din_ready = 1'b0;
    unique case (state)
      IDLE: begin
        busy      = 1'b0;
        din_ready = 1'b1;
      end
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      PARITY:  tx = par_out;
      STOP:    tx = 1'b1;
      default: begin
        busy      = 1'b0;
        din_ready = 1'b0;
      end
    endcase
  end

endmodule
